// File: rtl/dmem_if.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_if : two-lane memory-stage request / response bundle
// rev 1.0
// ------------------------------------------------------------------
interface dmem_if #(
  parameter int DATA_W = 32
);
  logic [1:0]                   req_valid;
  logic [1:0]                   req_we;
  logic [1:0][31:0]             req_addr;
  logic [1:0][DATA_W-1:0]       req_wdata;
  logic [1:0][DATA_W/8-1:0]     req_be;
  logic                         stall_out;
  logic                         rsp_valid;
  logic [1:0][DATA_W-1:0]       rsp_rdata;
  logic [1:0]                   rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  stall_out, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output stall_out, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_responder : serialises two request lanes onto a 1-cycle RAM
// rev 1.0
// ------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  dmem_if.slave     bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L0   = 3'd1,
    S_L1   = 3'd2,
    S_RD   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_next;

  logic [1:0]                r_valid;
  logic [1:0]                r_we;
  logic [1:0][ADDR_W-1:0]    r_idx;
  logic [1:0][DATA_W-1:0]    r_wdata;
  logic [1:0][BE_W-1:0]      r_be;
  logic [1:0]                r_err;
  logic [1:0][DATA_W-1:0]    r_rdata;

  logic [DATA_W-1:0]         r_mem [DEPTH];
  logic [DATA_W-1:0]         r_ram_rdata;

  logic                      w_stall;
  logic                      w_ram_en;
  logic                      w_lane;
  logic                      w_cap0;
  logic                      w_cap_last;
  logic                      w_last;
  logic [1:0]                w_mis;
  logic [ADDR_W-1:0]         w_ram_idx;
  logic                      w_ram_we;
  logic [DATA_W-1:0]         w_ram_wdata;
  logic [BE_W-1:0]           w_ram_be;
  logic                      w_unused_addr_bits;

  // Upper address bits alias onto the same word and are deliberately ignored.
  assign w_unused_addr_bits = ^{bus.req_addr[0][31:ADDR_W+2], bus.req_addr[1][31:ADDR_W+2]};

  assign w_mis[0] = bus.req_valid[0] & (bus.req_addr[0][1:0] != 2'b00);
  assign w_mis[1] = bus.req_valid[1] & (bus.req_addr[1][1:0] != 2'b00);

  // Lane whose read data is still in flight when RD is reached.
  assign w_last = r_valid[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_ram_en   = 1'b0;
    w_lane     = 1'b0;
    w_cap0     = 1'b0;
    w_cap_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = |bus.req_valid;
        if (|bus.req_valid) begin
          w_next = bus.req_valid[0] ? S_L0 : S_L1;
        end
      end
      S_L0: begin
        w_stall  = 1'b1;
        w_ram_en = ~r_err[0];
        w_lane   = 1'b0;
        w_next   = r_valid[1] ? S_L1 : S_RD;
      end
      S_L1: begin
        w_stall  = 1'b1;
        w_ram_en = ~r_err[1];
        w_lane   = 1'b1;
        w_cap0   = r_valid[0] & ~r_we[0] & ~r_err[0];
        w_next   = S_RD;
      end
      S_RD: begin
        w_stall    = 1'b1;
        w_cap_last = r_valid[w_last] & ~r_we[w_last] & ~r_err[w_last];
        w_next     = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_ram_idx   = r_idx[w_lane];
  assign w_ram_we    = r_we[w_lane];
  assign w_ram_wdata = r_wdata[w_lane];
  assign w_ram_be    = r_be[w_lane];

  // Single-port RAM; read data appears the cycle after the access.
  always_ff @(posedge clk) begin
    if (w_ram_en) begin
      if (w_ram_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (w_ram_be[b]) begin
            r_mem[w_ram_idx][8*b +: 8] <= w_ram_wdata[8*b +: 8];
          end
        end
      end
      r_ram_rdata <= r_mem[w_ram_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_we    <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_err   <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && (|bus.req_valid)) begin
        r_valid    <= bus.req_valid;
        r_we       <= bus.req_we;
        r_idx[0]   <= bus.req_addr[0][ADDR_W+1:2];
        r_idx[1]   <= bus.req_addr[1][ADDR_W+1:2];
        r_wdata    <= bus.req_wdata;
        r_be       <= bus.req_be;
        r_err      <= w_mis;
        r_rdata    <= '0;
      end
      if (w_cap0) begin
        r_rdata[0] <= r_ram_rdata;
      end
      if (w_cap_last) begin
        r_rdata[w_last] <= r_ram_rdata;
      end
    end
  end

  assign bus.stall_out = w_stall;
  assign bus.rsp_valid = (r_state == S_DONE);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_dmem_responder : directed vectors against a byte-level memory model
// rev 1.0
// ------------------------------------------------------------------
module tb_dmem_responder;

  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_if #(.DATA_W(32)) bus();

  dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Expected response of the current transaction
  bit          act  = 1'b0;
  bit          have = 1'b0;
  int          acc  = 0;
  int          lat  = 0;
  logic [31:0] exp_rd [2];
  logic [1:0]  exp_err;

  logic [7:0]  mbytes [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic int base_of(input logic [31:0] a);
    logic [31:0] t;
    t = (a & 32'hFFFF_FFFC) % (32'd4 << ADDR_W);
    return int'(t);
  endfunction

  function automatic logic [31:0] rd_word(input int base);
    logic [31:0] w;
    for (int b = 0; b < 4; b++)
      w[8*b +: 8] = mbytes.exists(base + b) ? mbytes[base + b] : 8'h00;
    return w;
  endfunction

  task automatic st_word(input int base, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) mbytes[base + b] = d[8*b +: 8];
  endtask

  // Per-cycle comparison of all outputs against the expected transaction timeline
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_stall", 32'(bus.stall_out), 32'd0);
      chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rdata0", bus.rsp_rdata[0], 32'd0);
      chk("rst_rdata1", bus.rsp_rdata[1], 32'd0);
      chk("rst_err", 32'(bus.rsp_err), 32'd0);
    end else begin
      chk("stall", 32'(bus.stall_out), 32'(act && cyc >= acc && cyc < acc + lat));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(act && cyc == acc + lat));
      if (!act || cyc >= acc + lat) begin
        chk("rdata0", bus.rsp_rdata[0], have ? exp_rd[0] : 32'd0);
        chk("rdata1", bus.rsp_rdata[1], have ? exp_rd[1] : 32'd0);
        chk("err", 32'(bus.rsp_err), have ? 32'(exp_err) : 32'd0);
      end
    end
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] b0, input logic [3:0] b1);
    bus.req_valid    = v;
    bus.req_we       = we;
    bus.req_addr[0]  = a0;
    bus.req_addr[1]  = a1;
    bus.req_wdata[0] = d0;
    bus.req_wdata[1] = d1;
    bus.req_be[0]    = b0;
    bus.req_be[1]    = b1;
  endtask

  // Issue one request, update the model in lane order, and return in the DONE cycle
  task automatic issue(input logic [1:0] v, input logic [1:0] we,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] b0, input logic [3:0] b1);
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [3:0]  be [2];
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1; be[0] = b0; be[1] = b1;
    @(posedge clk); #1;
    drive(v, we, a0, a1, d0, d1, b0, b1);
    for (int i = 0; i < 2; i++) begin
      exp_err[i] = v[i] && (a[i][1:0] != 2'b00);
      exp_rd[i]  = 32'd0;
      if (v[i] && !exp_err[i]) begin
        if (we[i]) st_word(base_of(a[i]), d[i], be[i]);
        else       exp_rd[i] = rd_word(base_of(a[i]));
      end
    end
    acc  = cyc;
    lat  = 2 + int'(v[0]) + int'(v[1]);
    act  = 1'b1;
    have = 1'b1;
    repeat (lat) @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 4'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Lane0 store then lane0 load
    issue(2'b01, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0);
    issue(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    chk("lit_load_deadbeef", bus.rsp_rdata[0], 32'hDEADBEEF);

    // Lane0 store forwarded to lane1 load in the same request
    issue(2'b11, 2'b01, 32'h20, 32'h20, 32'h12345678, 32'h0, 4'hF, 4'h0);
    chk("lit_fwd_rdata1", bus.rsp_rdata[1], 32'h12345678);
    chk("lit_fwd_rdata0", bus.rsp_rdata[0], 32'h0);
    chk("lit_fwd_valid", 32'(bus.rsp_valid), 32'd1);

    // Partial byte-enable merge
    issue(2'b01, 2'b01, 32'h30, 32'h0, 32'hAABBCCDD, 32'h0, 4'hF, 4'h0);
    issue(2'b01, 2'b01, 32'h30, 32'h0, 32'h11223344, 32'h0, 4'b0101, 4'h0);
    issue(2'b10, 2'b00, 32'h3, 32'h30, 32'h0, 32'h0, 4'h0, 4'h0);
    chk("lit_be_merge", bus.rsp_rdata[1], 32'hAA22CC44);
    chk("lit_inv_lane_err", 32'(bus.rsp_err), 32'd0);

    // Misaligned lane0, aligned lane1
    issue(2'b11, 2'b00, 32'h13, 32'h20, 32'h0, 32'h0, 4'h0, 4'h0);
    chk("lit_mis_err", 32'(bus.rsp_err), 32'b01);
    chk("lit_mis_rdata0", bus.rsp_rdata[0], 32'h0);
    chk("lit_mis_rdata1", bus.rsp_rdata[1], 32'h12345678);

    // Address aliasing above the RAM depth
    issue(2'b11, 2'b00, 32'h10, 32'h10 + (32'd4 << ADDR_W), 32'h0, 32'h0, 4'h0, 4'h0);
    chk("lit_alias_rdata1", bus.rsp_rdata[1], 32'hDEADBEEF);
    chk("lit_alias_err", 32'(bus.rsp_err), 32'd0);

    // be=0 store is a no-op; misaligned store on lane1 is dropped
    issue(2'b01, 2'b01, 32'h10, 32'h0, 32'h55555555, 32'h0, 4'h0, 4'h0);
    issue(2'b11, 2'b10, 32'h10, 32'h22, 32'h0, 32'h99999999, 4'h0, 4'hF);
    chk("lit_be0_noop", bus.rsp_rdata[0], 32'hDEADBEEF);
    chk("lit_mis_store_err", 32'(bus.rsp_err), 32'b10);
    repeat (3) @(posedge clk);
    issue(2'b01, 2'b00, 32'h20, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    chk("lit_mis_store_dropped", bus.rsp_rdata[0], 32'h12345678);

    // Reset while lane1 is being serviced
    @(posedge clk); #1;
    drive(2'b11, 2'b01, 32'h40, 32'h40, 32'hCAFEF00D, 32'h0, 4'hF, 4'h0);
    exp_err = 2'b00; exp_rd[0] = 32'd0; exp_rd[1] = 32'hCAFEF00D;
    st_word(base_of(32'h40), 32'hCAFEF00D, 4'hF);
    acc = cyc; lat = 4; act = 1'b1; have = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = 2'b00;
    act = 1'b0;
    have = 1'b0;
    #1;
    chk("lit_rst_stall", 32'(bus.stall_out), 32'd0);
    chk("lit_rst_rdata1", bus.rsp_rdata[1], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    issue(2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    chk("lit_rst_store_kept", bus.rsp_rdata[0], 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
